// File: rtl/gg_univ_reg.sv
// gg_univ_reg: parametrised universal register (hold/load/shift/rotate/count).
// Ports: CK clock, CLR sync clear, EN active-low enable, M mode, D load data,
//        SI serial in, Q contents, CO carry/shift-out/terminal, Z zero flag.
module gg_univ_reg #(
    parameter int W     = 8,
    parameter bit SAT   = 1'b0,
    parameter int Dck_q = 1
) (
    input  logic         CK,
    input  logic         CLR,
    input  logic         EN,
    input  logic [2:0]   M,
    input  logic [W-1:0] D,
    input  logic         SI,
    output logic [W-1:0] Q,
    output logic         CO,
    output logic         Z
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_INC  = 3'd6,
        MODE_DEC  = 3'd7
    } mode_e;

    // Elaboration-time guards on the parameter range. Dck_q describes the
    // clock-to-output delay of the modelled primitive; the synthesized
    // register has no explicit delay.
    if (W < 2 || W > 32) begin : g_bad_width
        $error("gg_univ_reg: W must be in 2..32");
    end
    if (Dck_q < 0) begin : g_bad_delay
        $error("gg_univ_reg: Dck_q must be non-negative");
    end

    logic [W-1:0] q;
    logic         co;
    logic [W-1:0] q_nxt;
    logic         co_nxt;
    logic         all_ones;
    logic         is_zero;
    mode_e        mode;

    assign mode     = mode_e'(M);
    assign all_ones = &q;
    assign is_zero  = ~|q;

    // Next-state for an executing edge; both Q and CO derive from pre-edge Q.
    always_comb begin
        q_nxt  = q;
        co_nxt = 1'b0;
        case (mode)
            MODE_HOLD: begin
                q_nxt = q;
            end
            MODE_LOAD: begin
                q_nxt = D;
            end
            MODE_SHL: begin
                q_nxt  = {q[W-2:0], SI};
                co_nxt = q[W-1];
            end
            MODE_SHR: begin
                q_nxt  = {SI, q[W-1:1]};
                co_nxt = q[0];
            end
            MODE_ROL: begin
                q_nxt  = {q[W-2:0], q[W-1]};
                co_nxt = q[W-1];
            end
            MODE_ROR: begin
                q_nxt  = {q[0], q[W-1:1]};
                co_nxt = q[0];
            end
            MODE_INC: begin
                // Terminal count: wrap to zero, or stick at all-ones.
                if (all_ones) begin
                    q_nxt  = SAT ? q : '0;
                    co_nxt = 1'b1;
                end else begin
                    q_nxt  = q + W'(1);
                end
            end
            MODE_DEC: begin
                if (is_zero) begin
                    q_nxt  = SAT ? q : '1;
                    co_nxt = 1'b1;
                end else begin
                    q_nxt  = q - W'(1);
                end
            end
            // Unknown mode poisons the state.
            default: begin
                q_nxt  = 'x;
                co_nxt = 1'bx;
            end
        endcase
    end

    // CLR beats EN beats M. Unknown CLR or EN poisons the state.
    always_ff @(posedge CK) begin
        case (CLR)
            1'b1: begin
                q  <= '0;
                co <= 1'b0;
            end
            1'b0: begin
                case (EN)
                    1'b1: begin
                        q  <= q;
                        co <= co;
                    end
                    1'b0: begin
                        q  <= q_nxt;
                        co <= co_nxt;
                    end
                    default: begin
                        q  <= 'x;
                        co <= 1'bx;
                    end
                endcase
            end
            default: begin
                q  <= 'x;
                co <= 1'bx;
            end
        endcase
    end

    assign Q  = q;
    assign CO = co;
    assign Z  = (q == '0);

endmodule
